// File: rtl/ahb_pixel_scheduler_pkg.sv
// Shared definitions for the AHB pixel scheduler: register map, bit fields and FSM states.
package ahb_pixel_scheduler_pkg;
  localparam logic [1:0] REG_POINT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FRAME = 1;
  localparam int CTRL_FLUSH = 2;

  localparam int STAT_EMPTY = 4;
  localparam int STAT_FULL  = 5;
  localparam int STAT_OVF   = 6;
  localparam int STAT_BUSY  = 7;

  localparam int Y_LSB = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } state_t;
endpackage

// File: rtl/ahb_pixel_scheduler_fifo.sv
// Synchronous point FIFO with combinational head; flush overrides any push/pop in the same cycle.
module pixel_fifo
  import ahb_pixel_scheduler_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int W     = 22,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic [CNTW-1:0] count,
  output logic            empty,
  output logic            full
);
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNTW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CNTW'(1);
      else if (do_pop && !do_push) count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/ahb_pixel_scheduler.sv
// AHB-Lite slave queuing CPU-written pixel points and presenting them one at a time to the datapath.
//   state   | meaning
//   IDLE    | nothing presented; pops the head when enabled and FIFO not empty
//   PRESENT | pix_* valid and held until pix_ready
//   HOLDOFF | frame-paced wait for the next frame_tick (or enable dropping)
module ahb_pixel_scheduler
  import ahb_pixel_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 11
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_valid,
  input  logic          pix_ready,
  input  logic          frame_tick
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [1:0]      addr_q, addr_d;
  logic            wr_q, wr_d;
  logic            en_q, en_d, frame_q, frame_d, ovf_q, ovf_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic            pix_valid_q, pix_valid_d;
  logic            point_wr, ctrl_wr, stat_wr, flush, pop;
  logic [2*CW-1:0] fifo_dout;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_empty, fifo_full;
  logic            unused_bits;

  assign HREADYOUT   = 1'b1;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  pixel_fifo #(.DEPTH(DEPTH), .W(2*CW)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (point_wr),
    .pop   (pop),
    .flush (flush),
    .din   ({HWDATA[Y_LSB+CW-1:Y_LSB], HWDATA[CW-1:0]}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign point_wr = wr_q && (addr_q == REG_POINT);
  assign ctrl_wr  = wr_q && (addr_q == REG_CTRL);
  assign stat_wr  = wr_q && (addr_q == REG_STATUS);
  assign flush    = ctrl_wr && HWDATA[CTRL_FLUSH];

  always_comb begin
    addr_d  = addr_q;
    wr_d    = 1'b0;
    en_d    = en_q;
    frame_d = frame_q;
    ovf_d   = ovf_q;
    if (HREADY) begin
      addr_d = HADDR[3:2];
      wr_d   = HSEL && HWRITE && HTRANS[1];
    end
    if (ctrl_wr) begin
      en_d    = HWDATA[CTRL_EN];
      frame_d = HWDATA[CTRL_FRAME];
    end
    if (stat_wr && HWDATA[STAT_OVF])                    ovf_d = 1'b0;
    else if (point_wr && fifo_full && !pop && !flush)   ovf_d = 1'b1;
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      REG_CTRL: begin
        HRDATA[CTRL_EN]    = en_q;
        HRDATA[CTRL_FRAME] = frame_q;
      end
      REG_STATUS: begin
        HRDATA[3:0]        = 4'(fifo_count);
        HRDATA[STAT_EMPTY] = fifo_empty;
        HRDATA[STAT_FULL]  = fifo_full;
        HRDATA[STAT_OVF]   = ovf_q;
        HRDATA[STAT_BUSY]  = (state_q != IDLE);
      end
      default: HRDATA = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      frame_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_q && !fifo_empty) state_d = PRESENT;
      PRESENT: if (pix_valid_q && pix_ready) state_d = (en_q && frame_q) ? HOLDOFF : IDLE;
      HOLDOFF: if (frame_tick || !en_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = pix_valid_q;
    case (state_q)
      IDLE: if (en_q && !fifo_empty) begin
        pop         = 1'b1;
        pix_x_d     = fifo_dout[CW-1:0];
        pix_y_d     = fifo_dout[2*CW-1:CW];
        pix_valid_d = 1'b1;
      end
      PRESENT: if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_valid = pix_valid_q;
endmodule
